// File: rtl/found_report_uart_tx.sv
// Reports the recovered password once per reset: captures PASSWD_IN on FOUND and
// sends it, plus optional CR LF, as back-to-back 8N1 UART bytes on TXD.
module found_report_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PW_BYTES     = 5,
  parameter int SEND_EOL     = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  FOUND,
  input  logic [0:8*PW_BYTES-1] PASSWD_IN,
  output logic                  TXD,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int TMR_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = $clog2(PW_BYTES + 2);
  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PW_BYTES - 1 + 2 * SEND_EOL);
  localparam logic [BYTE_W-1:0] BYTE_CR   = BYTE_W'(PW_BYTES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t                  state_r;
  logic [0:8*PW_BYTES-1]   shadow_r;
  logic [TMR_W-1:0]        tmr_r;
  logic [3:0]              bit_idx_r;
  logic [BYTE_W-1:0]       byte_idx_r;
  logic                    txd_r;
  logic                    busy_r;
  logic                    done_r;
  logic [7:0]              pw_byte_s;
  logic [7:0]              cur_byte_s;
  logic                    bit_end_s;

  // Select the byte being sent; shadow bit 8b lands in the byte MSB
  always_comb begin
    pw_byte_s = 8'h00;
    for (int i = 0; i < PW_BYTES; i++) begin
      pw_byte_s = pw_byte_s | ({8{byte_idx_r == BYTE_W'(i)}} & shadow_r[8*i +: 8]);
    end
    if (byte_idx_r < BYTE_CR) begin
      cur_byte_s = pw_byte_s;
    end else if (byte_idx_r == BYTE_CR) begin
      cur_byte_s = 8'h0D;
    end else begin
      cur_byte_s = 8'h0A;
    end
    bit_end_s = (tmr_r == TMR_LAST);
  end

  // Report sequencer: TXD is loaded one edge ahead so every bit is registered
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r    <= IDLE;
      shadow_r   <= {(8*PW_BYTES){1'b0}};
      tmr_r      <= {TMR_W{1'b0}};
      bit_idx_r  <= 4'd0;
      byte_idx_r <= {BYTE_W{1'b0}};
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (FOUND) begin
            shadow_r   <= PASSWD_IN;
            state_r    <= START;
            txd_r      <= 1'b0;
            busy_r     <= 1'b1;
            tmr_r      <= {TMR_W{1'b0}};
            bit_idx_r  <= 4'd0;
            byte_idx_r <= {BYTE_W{1'b0}};
          end
        end
        START: begin
          if (bit_end_s) begin
            tmr_r     <= {TMR_W{1'b0}};
            bit_idx_r <= 4'd1;
            txd_r     <= cur_byte_s[0];
            state_r   <= DATA;
          end else begin
            tmr_r <= tmr_r + 1'b1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            tmr_r     <= {TMR_W{1'b0}};
            bit_idx_r <= bit_idx_r + 4'd1;
            if (bit_idx_r == 4'd8) begin
              txd_r   <= 1'b1;
              state_r <= STOP;
            end else begin
              txd_r <= cur_byte_s[bit_idx_r[2:0]];
            end
          end else begin
            tmr_r <= tmr_r + 1'b1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            tmr_r <= {TMR_W{1'b0}};
            if (byte_idx_r == BYTE_LAST) begin
              state_r <= FIN;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
              txd_r   <= 1'b1;
            end else begin
              byte_idx_r <= byte_idx_r + 1'b1;
              bit_idx_r  <= 4'd0;
              txd_r      <= 1'b0;
              state_r    <= START;
            end
          end else begin
            tmr_r <= tmr_r + 1'b1;
          end
        end
        FIN: begin
          state_r <= FIN;
        end
        default: begin
          state_r <= IDLE;
          txd_r   <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign TXD  = txd_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_found_report_uart_tx.sv
// Bench for found_report_uart_tx: two instances (4 clk/bit with EOL, 2 clk/bit
// without), an abstract waveform model compared every cycle, plus decoded bytes.
module tb_found_report_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v [2];
  logic        found_v [2];
  logic [39:0] pw_v    [2];
  logic        txd0, busy0, done0, txd1, busy1, done1;
  logic        txd_v [2], busy_v [2], done_v [2];
  int          cpb [2] = '{4, 2};
  int          eol [2] = '{1, 0};
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          chk_en   = 1'b0;

  found_report_uart_tx #(.CLKS_PER_BIT(4), .PW_BYTES(5), .SEND_EOL(1)) dut0 (
    .CLK(clk), .RST_N(rst_n_v[0]), .FOUND(found_v[0]), .PASSWD_IN(pw_v[0]),
    .TXD(txd0), .BUSY(busy0), .DONE(done0));

  found_report_uart_tx #(.CLKS_PER_BIT(2), .PW_BYTES(5), .SEND_EOL(0)) dut1 (
    .CLK(clk), .RST_N(rst_n_v[1]), .FOUND(found_v[1]), .PASSWD_IN(pw_v[1]),
    .TXD(txd1), .BUSY(busy1), .DONE(done1));

  always_comb begin
    txd_v[0] = txd0; busy_v[0] = busy0; done_v[0] = done0;
    txd_v[1] = txd1; busy_v[1] = busy1; done_v[1] = done1;
  end

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int frame_len(int u);
    return 10 * cpb[u] * (5 + 2 * eol[u]);
  endfunction

  // Line level at position pos of a report: slot = pos/c, 10 slots per byte
  function automatic logic model_bit(logic [39:0] pw, int pos, int c);
    int s;
    int b;
    int j;
    logic [7:0] v;
    s = pos / c;
    b = s / 10;
    j = s % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    if (b < 5) v = 8'(pw >> (8 * (4 - b)));
    else if (b == 5) v = 8'h0D;
    else v = 8'h0A;
    return v[j-1];
  endfunction

  logic [39:0] m_pw   [2];
  int          m_pos  [2];
  bit          m_busy [2];
  bit          m_done [2];

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (!rst_n_v[u]) begin
        m_busy[u] <= 1'b0;
        m_done[u] <= 1'b0;
        m_pos[u]  <= 0;
      end else if (m_busy[u]) begin
        if (m_pos[u] == frame_len(u) - 1) begin
          m_busy[u] <= 1'b0;
          m_done[u] <= 1'b1;
        end else begin
          m_pos[u] <= m_pos[u] + 1;
        end
      end else if (!m_done[u] && found_v[u]) begin
        m_pw[u]   <= pw_v[u];
        m_busy[u] <= 1'b1;
        m_pos[u]  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("txd%0d", u), 64'(txd_v[u]),
              64'(m_busy[u] ? model_bit(m_pw[u], m_pos[u], cpb[u]) : 1'b1));
        check($sformatf("busy%0d", u), 64'(busy_v[u]), 64'(m_busy[u]));
        check($sformatf("done%0d", u), 64'(done_v[u]), 64'(m_done[u]));
      end
    end
  end

  // Called one negedge after the capture edge; records TXD while BUSY
  task automatic run_frame(int u, int repulse_at, output int busy_cycles,
                           output logic [7:0] got[$], output logic bits[$]);
    int i;
    i = 0;
    bits = {};
    got = {};
    while (busy_v[u] === 1'b1 && i < 2000) begin
      bits.push_back(txd_v[u]);
      if (i == repulse_at) begin
        found_v[u] = 1'b1;
        pw_v[u] = 40'hFFFFFFFFFF;
      end else begin
        found_v[u] = 1'b0;
      end
      @(negedge clk);
      i++;
    end
    found_v[u] = 1'b0;
    check("frame_ends", 64'(i < 2000), 64'd1);
    busy_cycles = i;
    for (int g = 0; (g + 1) * 10 * cpb[u] <= bits.size(); g++) begin
      logic [7:0] v;
      for (int j = 0; j < 8; j++) v[j] = bits[(g * 10 + 1 + j) * cpb[u] + cpb[u] / 2];
      got.push_back(v);
    end
  endtask

  task automatic check_bytes(string name, logic [7:0] got[$], logic [7:0] exp[$]);
    check({name, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s_byte%0d", name, i), 64'(got[i]), 64'(exp[i]));
  endtask

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic       bits[$];
    logic       pat[10];
    int         bc;
    int         mism;

    rst_n_v[0] = 1'b0; rst_n_v[1] = 1'b0;
    found_v[0] = 1'b0; found_v[1] = 1'b0;
    pw_v[0] = 40'h0; pw_v[1] = 40'h0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_txd", 64'(txd_v[0]), 64'd1);
    check("rst_busy", 64'(busy_v[0]), 64'd0);
    check("rst_done", 64'(done_v[0]), 64'd0);
    rst_n_v[0] = 1'b1; rst_n_v[1] = 1'b1;

    // Idle with FOUND low
    repeat (50) @(negedge clk);
    check("idle_txd", 64'(txd_v[0]), 64'd1);
    check("idle_busy", 64'(busy_v[0]), 64'd0);
    check("idle_done", 64'(done_v[0]), 64'd0);

    // HELLO report
    pw_v[0] = 40'h48454C4C4F; found_v[0] = 1'b1;
    @(negedge clk);
    run_frame(0, -1, bc, got, bits);
    exp = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};
    check_bytes("hello", got, exp);
    check("hello_busy_len", 64'(bc), 64'd280);
    check("hello_done", 64'(done_v[0]), 64'd1);
    check("hello_start_bit", 64'(bits[0]), 64'd0);

    rst_n_v[0] = 1'b0;
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    check("rst2_done", 64'(done_v[0]), 64'd0);

    // Re-pulse with new value mid-frame, then again after DONE
    pw_v[0] = 40'h48454C4C4F; found_v[0] = 1'b1;
    @(negedge clk);
    run_frame(0, 100, bc, got, bits);
    check_bytes("repulse", got, exp);
    check("repulse_busy_len", 64'(bc), 64'd280);
    found_v[0] = 1'b1;
    @(negedge clk);
    found_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("fin_busy", 64'(busy_v[0]), 64'd0);
    check("fin_done", 64'(done_v[0]), 64'd1);
    check("fin_txd", 64'(txd_v[0]), 64'd1);

    // Reset mid data bit, then capture on release with FOUND held
    rst_n_v[0] = 1'b0;
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    pw_v[0] = 40'h48454C4C4F; found_v[0] = 1'b1;
    @(negedge clk);
    found_v[0] = 1'b0;
    repeat (56) @(negedge clk);
    check("mid_busy", 64'(busy_v[0]), 64'd1);
    rst_n_v[0] = 1'b0; found_v[0] = 1'b1; pw_v[0] = 40'h0000000001;
    @(negedge clk);
    check("abort_txd", 64'(txd_v[0]), 64'd1);
    check("abort_busy", 64'(busy_v[0]), 64'd0);
    rst_n_v[0] = 1'b1;
    @(negedge clk);
    run_frame(0, -1, bc, got, bits);
    exp = {8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0D, 8'h0A};
    check_bytes("one", got, exp);
    check("one_busy_len", 64'(bc), 64'd280);

    // FOUND together with reset: nothing captured
    rst_n_v[0] = 1'b0; found_v[0] = 1'b1; pw_v[0] = 40'h1234567890;
    @(negedge clk);
    rst_n_v[0] = 1'b1; found_v[0] = 1'b0;
    @(negedge clk);
    check("rstwin_txd", 64'(txd_v[0]), 64'd1);
    check("rstwin_busy", 64'(busy_v[0]), 64'd0);
    check("rstwin_done", 64'(done_v[0]), 64'd0);

    // No EOL, 2 clocks per bit
    pw_v[1] = 40'hA5A5A5A5A5; found_v[1] = 1'b1;
    @(negedge clk);
    run_frame(1, -1, bc, got, bits);
    exp = {8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    check_bytes("a5", got, exp);
    check("a5_busy_len", 64'(bc), 64'd100);
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    mism = 0;
    for (int i = 0; i < bits.size(); i++)
      if (bits[i] !== pat[(i / 2) % 10]) mism++;
    check("a5_wave_mismatches", 64'(mism), 64'd0);
    check("a5_done", 64'(done_v[1]), 64'd1);

    repeat (5) @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
